// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register carrying control bits, operands, a valid bit and a bubble counter.
// Latency: 1 cycle. All outputs come straight from flops.
// Backpressure: stall holds every field. Flush or an invalid input loads a zeroed bubble and bumps a saturating counter.
module id_ex_reg #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 9,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic              alusrc_in,
   input  logic              memtoreg_in,
   input  logic              regwrite_in,
   input  logic              memread_in,
   input  logic              memwrite_in,
   input  logic              branch_in,
   input  logic              jump_in,
   input  logic [1:0]        aluop_in,
   input  logic [PC_W-1:0]   pc_in,
   input  logic [DATA_W-1:0] rd1_in,
   input  logic [DATA_W-1:0] rd2_in,
   input  logic [DATA_W-1:0] imm_in,
   input  logic [4:0]        rs1_in,
   input  logic [4:0]        rs2_in,
   input  logic [4:0]        rd_in,
   input  logic [2:0]        funct3_in,
   input  logic [6:0]        funct7_in,
   output logic              alusrc_ex,
   output logic              memtoreg_ex,
   output logic              regwrite_ex,
   output logic              memread_ex,
   output logic              memwrite_ex,
   output logic              branch_ex,
   output logic              jump_ex,
   output logic [1:0]        aluop_ex,
   output logic [PC_W-1:0]   pc_ex,
   output logic [DATA_W-1:0] rd1_ex,
   output logic [DATA_W-1:0] rd2_ex,
   output logic [DATA_W-1:0] imm_ex,
   output logic [4:0]        rs1_ex,
   output logic [4:0]        rs2_ex,
   output logic [4:0]        rd_ex,
   output logic [2:0]        funct3_ex,
   output logic [6:0]        funct7_ex,
   output logic              valid_ex,
   output logic [CNT_W-1:0]  bubble_cnt
);

   // Everything the stage carries, so a bubble is simply an all-zero word.
   typedef struct packed {
      logic              alusrc;
      logic              memtoreg;
      logic              regwrite;
      logic              memread;
      logic              memwrite;
      logic              branch;
      logic              jump;
      logic [1:0]        aluop;
      logic [PC_W-1:0]   pc;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [DATA_W-1:0] imm;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [4:0]        rd;
      logic [2:0]        funct3;
      logic [6:0]        funct7;
   } stage_t;

   stage_t            stage_d;
   stage_t            stage_q;
   logic              valid_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              hold;
   logic              load_bubble;
   logic              cnt_sat;

   assign stage_d = {alusrc_in, memtoreg_in, regwrite_in, memread_in, memwrite_in,
                     branch_in, jump_in, aluop_in, pc_in, rd1_in, rd2_in, imm_in,
                     rs1_in, rs2_in, rd_in, funct3_in, funct7_in};

   // Flush overrides stall; otherwise an empty decode slot becomes a bubble.
   assign hold        = stall & ~flush;
   assign load_bubble = flush | ~in_valid;
   assign cnt_sat     = (cnt_q == {CNT_W{1'b1}});

   // Stage register: reset > flush > stall > load, with the bubble count saturating.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else if (!hold) begin
         if (load_bubble) begin
            stage_q <= '0;
            valid_q <= 1'b0;
            if (!cnt_sat) begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            stage_q <= stage_d;
            valid_q <= 1'b1;
         end
      end
   end

   assign {alusrc_ex, memtoreg_ex, regwrite_ex, memread_ex, memwrite_ex,
           branch_ex, jump_ex, aluop_ex, pc_ex, rd1_ex, rd2_ex, imm_ex,
           rs1_ex, rs2_ex, rd_ex, funct3_ex, funct7_ex} = stage_q;
   assign valid_ex   = valid_q;
   assign bubble_cnt = cnt_q;

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
Pipeline register between the decode stage (main controller + register file + immediate generator) and the execute stage of the RV32 pipelined core. Each cycle it captures the controller's decoded control bits together with the decode-stage operands. It supports stall (hold), flush (bubble insertion) and a valid bit. A saturating counter reports the number of bubbles inserted, for performance monitoring.

Parameters:
DATA_W, 32, width of register operands and immediate
PC_W, 9, width of the instruction address
CNT_W, 16, width of the bubble counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold all stage contents (load-use hazard from hazard unit)
flush  in  1  replace next contents with a bubble (taken branch/jump)
in_valid  in  1  decode stage holds a real instruction
alusrc_in, memtoreg_in, regwrite_in, memread_in, memwrite_in, branch_in, jump_in  in  1 each  controller outputs
aluop_in  in  2  controller ALUOp (00 LW/SW, 01 branch, 10 R/I-type, 11 jal/jalr)
pc_in  in  PC_W  instruction PC
rd1_in, rd2_in  in  DATA_W  register file read data
imm_in  in  DATA_W  sign-extended immediate
rs1_in, rs2_in, rd_in  in  5 each  register indices
funct3_in  in  3; funct7_in  in  7  instruction fields
*_ex (one per *_in above)  out  same widths  registered copies
valid_ex  out  1  execute stage holds a real instruction
bubble_cnt  out  CNT_W  saturating count of bubbles loaded

Behaviour:
- Every action happens on the rising edge of clk. Outputs come straight from flops, so latency is 1 cycle.
- Priority on each edge: reset > flush > stall > load.
- reset=1: clear all *_ex outputs, valid_ex and bubble_cnt to 0.
- flush=1 (stall ignored): load a bubble.
  - All control outputs = 0 (aluop_ex=00).
  - valid_ex=0.
  - All data/index/PC outputs = 0.
  - bubble_cnt increments.
- stall=1, flush=0: every output, including valid_ex, holds its value. bubble_cnt does not change.
- Load (stall=0, flush=0):
  - If in_valid=1: copy every *_in to *_ex and set valid_ex=1.
  - If in_valid=0: load a bubble exactly as for flush, and bubble_cnt increments.
- Bubble invariant: whenever valid_ex=0, regwrite_ex, memwrite_ex, memread_ex, branch_ex and jump_ex are all 0. No architectural side effect may leak from a bubble.
- bubble_cnt saturates at 2^CNT_W-1 and never wraps. An increment at saturation leaves it unchanged.
- Data fields pass through unmodified. No sign extension or width change is done here.
- Reset asserted mid-stall or together with flush: reset wins, and the next cycle starts from the all-zero state.
- Inputs are sampled only at the edge. Combinational glitches between edges have no effect.

Test Plan:
- Reset: assert reset for 2 cycles with random inputs → all outputs 0, valid_ex=0, bubble_cnt=0.
- Normal load: LW (alusrc=1, memtoreg=1, regwrite=1, memread=1, aluop=00), pc_in=0x04, rd1_in=0x100, imm_in=0x8, rd_in=5, in_valid=1 → next edge: outputs mirror inputs, valid_ex=1.
- Stall: after loading an R-type (regwrite=1, aluop=10, rd=7), hold stall=1 for 3 cycles while inputs change → outputs stay at the R-type values; bubble_cnt unchanged.
- Flush vs stall: stall=1 and flush=1 on the same edge while holding a SW → all controls 0, valid_ex=0, memwrite_ex=0; bubble_cnt +1.
- Invalid input: in_valid=0 with regwrite_in=1, memwrite_in=1 → regwrite_ex=0, memwrite_ex=0, valid_ex=0; bubble_cnt +1.
- Saturation: CNT_W=4, flush held for 20 cycles → bubble_cnt reaches 15 and stays 15. Then reset → 0.
